tl_reg_bridge: RTL and testbench
================================

# tl_reg_bridge

TileLink-UL to register-bus bridge sitting directly downstream of the TL bus bypass's out node, in front of the 9-bit-address, 32-bit debug register file. It accepts one single-beat TL-UL Get/PutFullData/PutPartialData at a time and issues a word-addressed register request. It waits for the register response, then returns AccessAck or AccessAckData on the D channel. Illegal requests, and requests that time out, are answered locally with denied.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: register-response wait limit in cycles. Legal range 1..65535.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width. Derived; do not override.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- auto_in_a_valid / auto_in_a_ready  in/out  1  TL A handshake
- auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- auto_in_a_bits_address  in  9  byte address
- auto_in_a_bits_data  in  32  write data
- auto_in_d_valid / auto_in_d_ready  out/in  1  TL D handshake
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- auto_in_d_bits_param  out  2  constant 0
- auto_in_d_bits_size  out  2  constant 2
- auto_in_d_bits_source  out  1  constant 0
- auto_in_d_bits_sink  out  1  constant 0
- auto_in_d_bits_denied  out  1  error response
- auto_in_d_bits_data  out  32  read data; 0 when denied
- auto_in_d_bits_corrupt  out  1  = denied && opcode==AccessAckData
- reg_req_valid / reg_req_ready  out/in  1  register request handshake
- reg_req_write  out  1  1=write
- reg_req_addr  out  7  word address = a_address[8:2]
- reg_req_wdata  out  32  write data
- reg_resp_valid  in  1  one-cycle response strobe
- reg_resp_rdata  in  32  read data
- reg_resp_error  in  1  slave error

## Operation
- FSM states:
  - IDLE: a_ready=1. A fire with a legal request latches opcode, address and data, then goes to REQ. A fire with an illegal request goes to RESP with denied=1.
  - Illegal means opcode not in {0,1,4}, or address[1:0]!=0.
- REQ: reg_req_valid=1. On req fire, go to WAIT and clear the counter.
- WAIT: on reg_resp_valid, latch rdata (reads only; writes capture 0) and error→denied, then go to RESP. Otherwise the counter increments.
- RESP: d_valid=1, outputs held stable. On d fire, go to IDLE.
- Response opcode: Get→AccessAckData; Put*→AccessAck.
- reg_resp_valid outside WAIT is ignored.
- PutPartialData is treated as a full-word write; no mask exists on this link.
- Reset values: a_ready=0 while reset is asserted, then 1 in IDLE. d_valid=0, reg_req_valid=0, and every data or field output is 0. State is IDLE.
- Reset asserted mid-transaction: all state returns to IDLE immediately. The in-flight request is abandoned and no D response is generated.

## Timing
- Exactly one outstanding transaction. a_ready is 0 in REQ, WAIT and RESP.
- Minimum legal-read latency, with A fire at cycle 0:
  - reg_req_valid at cycle 1.
  - With req_ready=1, WAIT at cycle 2.
  - With resp_valid at cycle 2, d_valid at cycle 3.
- Illegal request: d_valid at cycle 1.
- reg_req_valid, once asserted, stays high with stable payload until reg_req_ready.
- d_valid, once asserted, stays high with stable payload until d_ready.
- Back-to-back: d fire at cycle N gives a_ready=1 at cycle N+1.

## Configuration
- TL_REG_BRIDGE_TIMEOUT_EN defined:
  - When the counter reaches TIMEOUT_CYCLES in WAIT, the FSM goes to RESP with denied=1 and data=0.
  - If reg_resp_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the response wins.
  - A late reg_resp_valid arriving after the timeout is ignored.
- TL_REG_BRIDGE_TIMEOUT_EN undefined:
  - No counter is built. WAIT persists until reg_resp_valid.
  - TIMEOUT_CYCLES is unused.

## Structure
- Package tl_reg_bridge_pkg contains:
  - TL opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1.
  - State enum: IDLE, REQ, WAIT, RESP.
  - Constants REG_ADDR_W=7 and DATA_W=32.
- One sub-module, tl_reg_bridge_timer, holds the CNT_W counter with clear, enable and expired outputs.
  - Instantiated only under TL_REG_BRIDGE_TIMEOUT_EN.

## Test plan
- Get at address 0x044, req_ready=1, resp at cycle 2 with rdata=0xDEADBEEF, error=0:
  - reg_req_addr=0x11, reg_req_write=0.
  - D at cycle 3 with opcode=1, data=0xDEADBEEF, denied=0, corrupt=0.
- PutFullData at address 0x010 with data 0x12345678, req_ready held low for 4 cycles, resp error=1:
  - Request payload stays stable throughout the stall.
  - D response: opcode=0, denied=1, corrupt=0.
- Get at address 0x042 (misaligned), and separately opcode=2:
  - No reg_req_valid is ever issued.
  - D at cycle 1 with denied=1; the Get also has corrupt=1 and data=0.
- With TL_REG_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, Get with no response:
  - D with denied=1 and corrupt=1, exactly 8 cycles after entering WAIT.
  - A resp_valid arriving later is ignored, and the next transaction completes normally.
- d_ready held low for 5 cycles, then two back-to-back Gets:
  - d_valid and the payload stay stable during the stall.
  - a_ready=0 until the cycle after d fire.
- Reset asserted during WAIT:
  - reg_req_valid=0 and d_valid=0 immediately.
  - After release, a_ready=1 and no stale D response appears.

Source files
------------

// File: rtl/tl_reg_bridge_pkg.sv
// Shared TileLink-UL opcodes, FSM state encoding and widths for the
// TL-UL to register-bus bridge.
package tl_reg_bridge_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int REG_ADDR_W = 7;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  // Only word-aligned Get/PutFull/PutPartial reach the register file.
  function automatic logic is_legal(input logic [2:0] opcode, input logic [8:0] address);
    return ((opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == GET)) &&
           (address[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/tl_reg_bridge_timer.sv
// Register-response timeout counter for tl_reg_bridge; only instantiated
// when TL_REG_BRIDGE_TIMEOUT_EN is defined.
module tl_reg_bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Expiry fires in the cycle whose increment would reach TIMEOUT_CYCLES,
  // so RESP starts exactly TIMEOUT_CYCLES cycles after entering WAIT.
  assign expired = enable && (cnt_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tl_reg_bridge.sv
// Single-outstanding TL-UL to register-bus bridge. Optional response
// timeout is built when TL_REG_BRIDGE_TIMEOUT_EN is defined.
module tl_reg_bridge
  import tl_reg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  auto_in_a_valid,
  output logic                  auto_in_a_ready,
  input  logic [2:0]            auto_in_a_bits_opcode,
  input  logic [8:0]            auto_in_a_bits_address,
  input  logic [DATA_W-1:0]     auto_in_a_bits_data,
  output logic                  auto_in_d_valid,
  input  logic                  auto_in_d_ready,
  output logic [2:0]            auto_in_d_bits_opcode,
  output logic [1:0]            auto_in_d_bits_param,
  output logic [1:0]            auto_in_d_bits_size,
  output logic                  auto_in_d_bits_source,
  output logic                  auto_in_d_bits_sink,
  output logic                  auto_in_d_bits_denied,
  output logic [DATA_W-1:0]     auto_in_d_bits_data,
  output logic                  auto_in_d_bits_corrupt,
  output logic                  reg_req_valid,
  input  logic                  reg_req_ready,
  output logic                  reg_req_write,
  output logic [REG_ADDR_W-1:0] reg_req_addr,
  output logic [DATA_W-1:0]     reg_req_wdata,
  input  logic                  reg_resp_valid,
  input  logic [DATA_W-1:0]     reg_resp_rdata,
  input  logic                  reg_resp_error
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) ||
      (CNT_W != $clog2(TIMEOUT_CYCLES + 1))) begin : g_bad_param
    $error("tl_reg_bridge: TIMEOUT_CYCLES must be 1..65535 and CNT_W left derived");
  end

  state_e                state_q, state_d;
  logic                  alive_q;
  logic                  req_write_q;
  logic [REG_ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0]     req_wdata_q;
  logic [2:0]            d_opcode_q;
  logic                  d_denied_q;
  logic [DATA_W-1:0]     d_data_q;

  logic a_fire;
  logic legal;
  logic timed_out;

  assign auto_in_a_ready = alive_q && (state_q == IDLE);
  assign a_fire          = auto_in_a_valid && auto_in_a_ready;
  assign legal           = is_legal(auto_in_a_bits_opcode, auto_in_a_bits_address);

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
  tl_reg_bridge_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   ((state_q == REQ) && reg_req_ready),
    .enable  (state_q == WAIT),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_fire) state_d = legal ? REQ : RESP;
      REQ:     if (reg_req_ready) state_d = WAIT;
      WAIT:    if (reg_resp_valid || timed_out) state_d = RESP;
      RESP:    if (auto_in_d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      d_opcode_q  <= ACCESS_ACK;
      d_denied_q  <= 1'b0;
      d_data_q    <= '0;
    end else begin
      if (a_fire) begin
        req_write_q <= (auto_in_a_bits_opcode != GET);
        req_addr_q  <= auto_in_a_bits_address[8:2];
        req_wdata_q <= auto_in_a_bits_data;
        d_opcode_q  <= (auto_in_a_bits_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
        d_denied_q  <= !legal;
        d_data_q    <= '0;
      end
      // A response in the expiry cycle takes priority over the timeout.
      if (state_q == WAIT) begin
        if (reg_resp_valid) begin
          d_data_q   <= req_write_q ? '0 : reg_resp_rdata;
          d_denied_q <= reg_resp_error;
        end else if (timed_out) begin
          d_data_q   <= '0;
          d_denied_q <= 1'b1;
        end
      end
    end
  end

  assign reg_req_valid = (state_q == REQ);
  assign reg_req_write = req_write_q;
  assign reg_req_addr  = req_addr_q;
  assign reg_req_wdata = req_wdata_q;

  assign auto_in_d_valid        = (state_q == RESP);
  assign auto_in_d_bits_opcode  = d_opcode_q;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = 2'd2;
  assign auto_in_d_bits_source  = 1'b0;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = d_denied_q;
  assign auto_in_d_bits_data    = d_data_q;
  assign auto_in_d_bits_corrupt = d_denied_q && (d_opcode_q == ACCESS_ACK_DATA);

endmodule

// File: tb/tb_tl_reg_bridge.sv
// Directed self-checking bench for tl_reg_bridge; the timeout scenario is
// exercised when TL_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_tl_reg_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [8:0]  a_address;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic        d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int checks   = 0;
  int failures = 0;
  int req_count = 0;
  int snap;

  always #5 clock = ~clock;

  always @(posedge clock) if (req_valid) req_count++;

  tl_reg_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_data    (a_data),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt),
    .reg_req_valid          (req_valid),
    .reg_req_ready          (req_ready),
    .reg_req_write          (req_write),
    .reg_req_addr           (req_addr),
    .reg_req_wdata          (req_wdata),
    .reg_resp_valid         (resp_valid),
    .reg_resp_rdata         (resp_rdata),
    .reg_resp_error         (resp_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full legal Get with an immediate slave; leaves the bridge idle one
  // cycle after the D fire so calls can run back to back.
  task automatic do_get(input string tag, input logic [8:0] addr, input logic [6:0] word,
                        input logic [31:0] rdata);
    a_valid = 1'b1; a_opcode = 3'd4; a_address = addr; req_ready = 1'b1; d_ready = 1'b1;
    check({tag, "_a_ready"}, 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check({tag, "_req_valid"}, 32'(req_valid), 32'd1);
    check({tag, "_req_addr"}, 32'(req_addr), 32'(word));
    check({tag, "_req_write"}, 32'(req_write), 32'd0);
    step();
    check({tag, "_wait_d_valid"}, 32'(d_valid), 32'd0);
    resp_valid = 1'b1; resp_rdata = rdata; resp_error = 1'b0;
    step();
    resp_valid = 1'b0;
    check({tag, "_d_valid"}, 32'(d_valid), 32'd1);
    check({tag, "_d_opcode"}, 32'(d_opcode), 32'd1);
    check({tag, "_d_data"}, d_data, rdata);
    check({tag, "_d_denied"}, 32'(d_denied), 32'd0);
    check({tag, "_d_corrupt"}, 32'(d_corrupt), 32'd0);
    check({tag, "_resp_a_ready"}, 32'(a_ready), 32'd0);
    step();
    check({tag, "_d_done"}, 32'(d_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; a_valid = 1'b0; a_opcode = 3'd0; a_address = 9'd0; a_data = 32'd0;
    d_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'd0; resp_error = 1'b0;

    // Reset state
    step(); step();
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_d_data", d_data, 32'd0);
    check("rst_req_addr", 32'(req_addr), 32'd0);
    check("rst_d_size", 32'(d_size), 32'd2);
    check("rst_d_param", 32'({d_param, d_source, d_sink}), 32'd0);
    reset = 1'b1;
    step();
    check("post_rst_a_ready", 32'(a_ready), 32'd1);

    // Get 0x044, minimum latency
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 9'h044; req_ready = 1'b1; d_ready = 1'b0;
    check("get_a_ready_c0", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check("get_req_valid_c1", 32'(req_valid), 32'd1);
    check("get_req_addr", 32'(req_addr), 32'h11);
    check("get_req_write", 32'(req_write), 32'd0);
    check("get_a_ready_c1", 32'(a_ready), 32'd0);
    step();
    check("get_req_valid_c2", 32'(req_valid), 32'd0);
    check("get_d_valid_c2", 32'(d_valid), 32'd0);
    resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF; resp_error = 1'b0;
    step();
    resp_valid = 1'b0;
    check("get_d_valid_c3", 32'(d_valid), 32'd1);
    check("get_d_opcode", 32'(d_opcode), 32'd1);
    check("get_d_data", d_data, 32'hDEADBEEF);
    check("get_d_denied", 32'(d_denied), 32'd0);
    check("get_d_corrupt", 32'(d_corrupt), 32'd0);
    d_ready = 1'b1;
    step();
    check("get_done_d_valid", 32'(d_valid), 32'd0);
    check("get_done_a_ready", 32'(a_ready), 32'd1);

    // PutFull 0x010 with a 4-cycle request stall and an error response
    a_valid = 1'b1; a_opcode = 3'd0; a_address = 9'h010; a_data = 32'h12345678; req_ready = 1'b0;
    step();
    a_valid = 1'b0; a_address = 9'h000; a_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("put_stall_req_valid", 32'(req_valid), 32'd1);
      check("put_stall_req_addr", 32'(req_addr), 32'h04);
      check("put_stall_req_write", 32'(req_write), 32'd1);
      check("put_stall_req_wdata", req_wdata, 32'h12345678);
      if (i == 3) req_ready = 1'b1;
      step();
    end
    check("put_wait_req_valid", 32'(req_valid), 32'd0);
    resp_valid = 1'b1; resp_error = 1'b1; resp_rdata = 32'hCAFEF00D;
    step();
    resp_valid = 1'b0; resp_error = 1'b0;
    check("put_d_valid", 32'(d_valid), 32'd1);
    check("put_d_opcode", 32'(d_opcode), 32'd0);
    check("put_d_denied", 32'(d_denied), 32'd1);
    check("put_d_corrupt", 32'(d_corrupt), 32'd0);
    check("put_d_data", d_data, 32'd0);
    step();
    check("put_done_a_ready", 32'(a_ready), 32'd1);

    // PutPartial at the top word is a plain word write
    a_valid = 1'b1; a_opcode = 3'd1; a_address = 9'h1FC; a_data = 32'h000000A5;
    step();
    a_valid = 1'b0;
    check("pp_req_write", 32'(req_write), 32'd1);
    check("pp_req_addr", 32'(req_addr), 32'h7F);
    check("pp_req_wdata", req_wdata, 32'h000000A5);
    step();
    resp_valid = 1'b1; resp_rdata = 32'hFFFFFFFF;
    step();
    resp_valid = 1'b0;
    check("pp_d_opcode", 32'(d_opcode), 32'd0);
    check("pp_d_denied", 32'(d_denied), 32'd0);
    check("pp_d_data", d_data, 32'd0);
    step();

    // Illegal requests are answered locally
    snap = req_count;
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 9'h042;
    step();
    a_valid = 1'b0;
    check("misal_d_valid_c1", 32'(d_valid), 32'd1);
    check("misal_d_opcode", 32'(d_opcode), 32'd1);
    check("misal_d_denied", 32'(d_denied), 32'd1);
    check("misal_d_corrupt", 32'(d_corrupt), 32'd1);
    check("misal_d_data", d_data, 32'd0);
    check("misal_req_valid", 32'(req_valid), 32'd0);
    step();
    check("misal_done", 32'(d_valid), 32'd0);
    a_valid = 1'b1; a_opcode = 3'd2; a_address = 9'h010;
    step();
    a_valid = 1'b0;
    check("badop_d_valid_c1", 32'(d_valid), 32'd1);
    check("badop_d_denied", 32'(d_denied), 32'd1);
    check("badop_d_data", d_data, 32'd0);
    step();
    check("illegal_no_req", 32'(req_count - snap), 32'd0);

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    // Timeout: no response, D exactly 8 cycles after entering WAIT
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 9'h020;
    step();
    a_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      check("to_wait_d_valid", 32'(d_valid), 32'd0);
      step();
    end
    check("to_d_valid", 32'(d_valid), 32'd1);
    check("to_d_denied", 32'(d_denied), 32'd1);
    check("to_d_corrupt", 32'(d_corrupt), 32'd1);
    check("to_d_data", d_data, 32'd0);
    step();
    resp_valid = 1'b1; resp_rdata = 32'h55555555; resp_error = 1'b1;
    step();
    resp_valid = 1'b0; resp_error = 1'b0;
    check("to_late_resp_d_valid", 32'(d_valid), 32'd0);
    check("to_late_resp_a_ready", 32'(a_ready), 32'd1);
    do_get("to_next", 9'h024, 7'h09, 32'h0F0F0F0F);
`endif

    // D stall for 5 cycles, then back-to-back Gets
    d_ready = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 9'h008;
    step();
    a_valid = 1'b0;
    step();
    resp_valid = 1'b1; resp_rdata = 32'h0BADF00D;
    step();
    resp_valid = 1'b0; resp_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("dstall_d_valid", 32'(d_valid), 32'd1);
      check("dstall_d_data", d_data, 32'h0BADF00D);
      check("dstall_d_opcode", 32'(d_opcode), 32'd1);
      check("dstall_a_ready", 32'(a_ready), 32'd0);
      step();
    end
    d_ready = 1'b1;
    check("dfire_a_ready", 32'(a_ready), 32'd0);
    step();
    check("after_dfire_a_ready", 32'(a_ready), 32'd1);
    do_get("b2b_0", 9'h00C, 7'h03, 32'h11112222);
    do_get("b2b_1", 9'h1F0, 7'h7C, 32'h33334444);

    // Reset asserted in REQ, then in WAIT
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 9'h0FC; req_ready = 1'b0;
    step();
    a_valid = 1'b0;
    check("rstreq_req_valid_before", 32'(req_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstreq_req_valid", 32'(req_valid), 32'd0);
    step();
    reset = 1'b1;
    req_ready = 1'b1;
    step();
    check("rstreq_a_ready", 32'(a_ready), 32'd1);
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 9'h0FC;
    step();
    a_valid = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    check("rstwait_req_valid", 32'(req_valid), 32'd0);
    check("rstwait_d_valid", 32'(d_valid), 32'd0);
    check("rstwait_a_ready", 32'(a_ready), 32'd0);
    resp_valid = 1'b1; resp_rdata = 32'h77777777;
    step();
    resp_valid = 1'b0;
    reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rstwait_post_a_ready", 32'(a_ready), 32'd1);
      check("rstwait_post_d_valid", 32'(d_valid), 32'd0);
      step();
    end
    do_get("post_rst", 9'h100, 7'h40, 32'h89ABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
